// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared state type and field widths for the alarm controller
package alarm_pkg;

  localparam int TIME_W     = 7;
  localparam int SNZ_LEFT_W = 9;
  localparam int SNZ_CNT_W  = 3;
  localparam int RING_W     = 7;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } alarm_state_t;

endpackage

// File: rtl/alarm_match.sv
// rtl/alarm_match.sv - combinational alarm time compare; ALARM_DAY_MATCH_EN restricts it to the set weekday
module alarm_match
  import alarm_pkg::*;
#(
  parameter int NS = 60
) (
  input  logic              alarm_on,
  input  logic [TIME_W-1:0] tsec,
  input  logic [TIME_W-1:0] tmin,
  input  logic [TIME_W-1:0] thrs,
  input  logic [TIME_W-1:0] tday,
  input  logic [TIME_W-1:0] amin,
  input  logic [TIME_W-1:0] ahrs,
  input  logic [TIME_W-1:0] aday,
  output logic              match
);

  // A minute with fewer than two seconds has no distinct top-of-minute; never fire.
  localparam bit NS_OK = (NS >= 2);

  logic day_ok;

`ifdef ALARM_DAY_MATCH_EN
  assign day_ok = (tday == aday);
`else
  logic unused_day;
  assign unused_day = ^{tday, aday};
  assign day_ok     = 1'b1;
`endif

  // Only second 0 can match, so the alarm fires at most once per minute.
  assign match = NS_OK && alarm_on && (tsec == '0) &&
                 (tmin == amin) && (thrs == ahrs) && day_ok;

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm FSM with ring timeout, limited snooze, dismiss and master enable (option: ALARM_DAY_MATCH_EN)
module alarm_ctrl
  import alarm_pkg::*;
#(
  parameter int NS         = 60,
  parameter int RING_S     = 60,
  parameter int SNOOZE_S   = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TIME_W-1:0]     tsec,
  input  logic [TIME_W-1:0]     tmin,
  input  logic [TIME_W-1:0]     thrs,
  input  logic [TIME_W-1:0]     tday,
  input  logic [TIME_W-1:0]     amin,
  input  logic [TIME_W-1:0]     ahrs,
  input  logic [TIME_W-1:0]     aday,
  input  logic                  alarm_on,
  input  logic                  snooze_btn,
  input  logic                  dismiss_btn,
  output logic                  buzz,
  output logic                  snoozing,
  output logic [SNZ_LEFT_W-1:0] snooze_left,
  output logic [SNZ_CNT_W-1:0]  snooze_cnt
);

  localparam logic [RING_W-1:0]     RING_LAST = RING_W'(RING_S - 1);
  localparam logic [SNZ_LEFT_W-1:0] SNZ_LOAD  = SNZ_LEFT_W'(SNOOZE_S);
  localparam logic [SNZ_CNT_W-1:0]  SNZ_MAX   = SNZ_CNT_W'(MAX_SNOOZE);

  alarm_state_t          state_q, state_d;
  logic [RING_W-1:0]     ring_ct_q, ring_ct_d;
  logic [SNZ_LEFT_W-1:0] snz_left_q, snz_left_d;
  logic [SNZ_CNT_W-1:0]  snz_cnt_q, snz_cnt_d;
  logic                  buzz_q, snoozing_q;
  logic                  match;

  alarm_match #(
    .NS (NS)
  ) u_match (
    .alarm_on (alarm_on),
    .tsec     (tsec),
    .tmin     (tmin),
    .thrs     (thrs),
    .tday     (tday),
    .amin     (amin),
    .ahrs     (ahrs),
    .aday     (aday),
    .match    (match)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ring_ct_q  <= '0;
      snz_left_q <= '0;
      snz_cnt_q  <= '0;
      buzz_q     <= 1'b0;
      snoozing_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_ct_q  <= ring_ct_d;
      snz_left_q <= snz_left_d;
      snz_cnt_q  <= snz_cnt_d;
      // Flags are registered copies of the next state so they align with state_q.
      buzz_q     <= (state_d == RING);
      snoozing_q <= (state_d == SNOOZE);
    end
  end

  always_comb begin
    state_d    = state_q;
    ring_ct_d  = ring_ct_q;
    snz_left_d = snz_left_q;
    snz_cnt_d  = snz_cnt_q;
    case (state_q)
      IDLE: begin
        snz_left_d = '0;
        // Matches are ignored outside IDLE, so an active event never restarts.
        if (match) begin
          state_d   = RING;
          ring_ct_d = '0;
          snz_cnt_d = '0;
        end
      end
      RING: begin
        if (!alarm_on || dismiss_btn) begin
          state_d    = IDLE;
          snz_left_d = '0;
        end else if (snooze_btn && (snz_cnt_q < SNZ_MAX)) begin
          state_d    = SNOOZE;
          snz_left_d = SNZ_LOAD;
          snz_cnt_d  = snz_cnt_q + 1'b1;
        end else if (ring_ct_q == RING_LAST) begin
          state_d    = IDLE;
          snz_left_d = '0;
        end else begin
          ring_ct_d = ring_ct_q + 1'b1;
        end
      end
      SNOOZE: begin
        if (!alarm_on || dismiss_btn) begin
          state_d    = IDLE;
          snz_left_d = '0;
        end else if (snz_left_q == SNZ_LEFT_W'(1)) begin
          state_d    = RING;
          ring_ct_d  = '0;
          snz_left_d = '0;
        end else begin
          snz_left_d = snz_left_q - 1'b1;
        end
      end
      default: begin
        state_d    = IDLE;
        snz_left_d = '0;
      end
    endcase
  end

  assign buzz        = buzz_q;
  assign snoozing    = snoozing_q;
  assign snooze_left = snz_left_q;
  assign snooze_cnt  = snz_cnt_q;

endmodule
